// File: rtl/vetor_pkg.sv
// Shared definitions for the operand feeder and the downstream MAC stage.
package vetor_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, FINISH} state_t;

  localparam int WIDTH = 10;
  localparam int ACC_W = 22;

endpackage

// File: rtl/vetor_bank.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous read port.
module vetor_bank
  import vetor_pkg::*;
#(
  parameter int WIDTH  = vetor_pkg::WIDTH,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vetor_feeder.sv
// Streams (A[i], B[i]) operand pairs to a free-running MAC, preceded by an accumulator clear.
module vetor_feeder
  import vetor_pkg::*;
#(
  parameter int WIDTH  = vetor_pkg::WIDTH,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W:0]   len,
  input  logic              start,
  output logic              busy,
  output logic              acc_clear,
  output logic [WIDTH-1:0]  k,
  output logic [WIDTH-1:0]  l,
  output logic              pair_valid,
  output logic              last,
  output logic              done,
  output logic              wr_err
);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   len_q;
  logic [WIDTH-1:0]  a_rd;
  logic [WIDTH-1:0]  b_rd;
  logic              wr_ok;
  logic              at_end;
  logic              next_last;

  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] n);
    if (n > (ADDR_W+1)'(DEPTH)) return (ADDR_W+1)'(DEPTH);
    return n;
  endfunction

  // Banks only change while idle, so the read side never sees a half-updated pass.
  assign wr_ok = wr_en && (state == IDLE) && ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));

  // Read one element ahead so k/l can be registered straight from the banks.
  assign rd_addr   = (state == CLEAR) ? '0 : idx + ADDR_W'(1);
  assign at_end    = ({1'b0, idx} == len_q - (ADDR_W+1)'(1));
  assign next_last = ({1'b0, rd_addr} == len_q - (ADDR_W+1)'(1));

  vetor_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank_a (
    .clock (clock),
    .reset (reset),
    .we    (wr_ok && !wr_sel),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (a_rd)
  );

  vetor_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank_b (
    .clock (clock),
    .reset (reset),
    .we    (wr_ok && wr_sel),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (b_rd)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      len_q      <= '0;
      busy       <= 1'b0;
      acc_clear  <= 1'b0;
      k          <= '0;
      l          <= '0;
      pair_valid <= 1'b0;
      last       <= 1'b0;
      done       <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      acc_clear  <= 1'b0;
      done       <= 1'b0;
      pair_valid <= 1'b0;
      last       <= 1'b0;
      k          <= '0;
      l          <= '0;
      if (wr_en && state != IDLE) wr_err <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= CLEAR;
            len_q     <= clamp_len(len);
            idx       <= '0;
            busy      <= 1'b1;
            acc_clear <= 1'b1;
            wr_err    <= 1'b0;
          end
        end
        CLEAR, STREAM: begin
          if ((state == CLEAR && len_q == '0) || (state == STREAM && at_end)) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state      <= STREAM;
            idx        <= rd_addr;
            k          <= a_rd;
            l          <= b_rd;
            pair_valid <= 1'b1;
            last       <= next_last;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vetor_feeder.sv
// Directed bench for vetor_feeder with a behavioural downstream MAC.
module tb_vetor_feeder;
  import vetor_pkg::*;

  localparam int W  = 10;
  localparam int D  = 4;
  localparam int AW = 2;

  logic          clock   = 1'b0;
  logic          reset   = 1'b1;
  logic          wr_en   = 1'b0;
  logic          wr_sel  = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic [AW:0]   len     = '0;
  logic          start   = 1'b0;
  logic          busy, acc_clear, pair_valid, last, done, wr_err;
  logic [W-1:0]  k, l;
  logic [ACC_W-1:0] mac;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] expa [D];
  logic [W-1:0] expb [D];

  always #5 clock = ~clock;

  vetor_feeder #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .len        (len),
    .start      (start),
    .busy       (busy),
    .acc_clear  (acc_clear),
    .k          (k),
    .l          (l),
    .pair_valid (pair_valid),
    .last       (last),
    .done       (done),
    .wr_err     (wr_err)
  );

  // Downstream MAC: adds k*l every edge, forced to zero by acc_clear.
  always @(posedge clock or posedge reset) begin
    if (reset)          mac <= '0;
    else if (acc_clear) mac <= '0;
    else                mac <= mac + ACC_W'(k) * ACC_W'(l);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic sel, input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
    tick;
    wr_en = 1'b0;
  endtask

  task automatic load(input logic [W-1:0] a0, a1, a2, a3, b0, b1, b2, b3);
    expa[0] = a0; expa[1] = a1; expa[2] = a2; expa[3] = a3;
    expb[0] = b0; expb[1] = b1; expb[2] = b2; expb[3] = b3;
    for (int i = 0; i < D; i++) begin
      wr(1'b0, AW'(i), expa[i]);
      wr(1'b1, AW'(i), expb[i]);
    end
  endtask

  task automatic run_pass(input string nm, input logic [AW:0] ln, input int n,
                          input logic [ACC_W-1:0] fmac);
    len = ln; start = 1'b1;
    tick;
    start = 1'b0;
    chk({nm, "_t1_acc_clear"}, acc_clear, 1);
    chk({nm, "_t1_busy"}, busy, 1);
    chk({nm, "_t1_k"}, k, 0);
    chk({nm, "_t1_pair_valid"}, pair_valid, 0);
    chk({nm, "_t1_wr_err"}, wr_err, 0);
    for (int i = 0; i < n; i++) begin
      tick;
      chk($sformatf("%s_pair%0d_k", nm, i), k, expa[i]);
      chk($sformatf("%s_pair%0d_l", nm, i), l, expb[i]);
      chk($sformatf("%s_pair%0d_valid", nm, i), pair_valid, 1);
      chk($sformatf("%s_pair%0d_last", nm, i), last, (i == n - 1) ? 1 : 0);
      chk($sformatf("%s_pair%0d_busy", nm, i), busy, 1);
      chk($sformatf("%s_pair%0d_acc_clear", nm, i), acc_clear, 0);
    end
    tick;
    chk({nm, "_done"}, done, 1);
    chk({nm, "_done_busy"}, busy, 0);
    chk({nm, "_done_valid"}, pair_valid, 0);
    chk({nm, "_done_k"}, k, 0);
    chk({nm, "_done_last"}, last, 0);
    tick;
    chk({nm, "_after_done"}, done, 0);
    chk({nm, "_mac"}, mac, fmac);
  endtask

  initial begin
    tick;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_acc_clear", acc_clear, 0);
    chk("rst_k", k, 0);
    chk("rst_l", l, 0);
    chk("rst_pair_valid", pair_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_err", wr_err, 0);
    reset = 1'b0;
    tick;

    // Basic pass: 3*6=18, +4*7=46, +5*8=86.
    load(10'd3, 10'd4, 10'd5, 10'd0, 10'd6, 10'd7, 10'd8, 10'd0);
    run_pass("basic", 3'd3, 3, 22'd86);

    // Full-scale operands: 4*1023*1023 = 4186116 fits in 22 bits.
    load(10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023);
    run_pass("fullscale", 3'd4, 4, 22'd4186116);

    // Zero length: clear then done, accumulator reads 0.
    run_pass("len0", 3'd0, 0, 22'd0);

    // Start and write while streaming are ignored / flagged.
    load(10'd3, 10'd4, 10'd5, 10'd1023, 10'd6, 10'd7, 10'd8, 10'd1023);
    len = 3'd3; start = 1'b1;
    tick;
    start = 1'b0;
    chk("busy_t1_acc_clear", acc_clear, 1);
    tick;
    chk("busy_p0_k", k, 3);
    start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = 10'd99;
    tick;
    start = 1'b0; wr_en = 1'b0;
    chk("busy_p1_k", k, 4);
    chk("busy_p1_l", l, 7);
    chk("busy_wr_err", wr_err, 1);
    tick;
    chk("busy_p2_k", k, 5);
    chk("busy_p2_last", last, 1);
    tick;
    chk("busy_done", done, 1);
    tick;
    chk("busy_restart_ignored", busy, 0);
    chk("busy_restart_no_clear", acc_clear, 0);
    chk("busy_mac", mac, 86);
    chk("busy_wr_err_sticky", wr_err, 1);
    run_pass("a0_kept", 3'd1, 1, 22'd18);

    // Asynchronous reset in the middle of a stream.
    len = 3'd3; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    chk("arst_pre_valid", pair_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_k", k, 0);
    chk("arst_l", l, 0);
    chk("arst_valid", pair_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_last", last, 0);
    chk("arst_done", done, 0);
    tick;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("arst_no_done%0d", i), done, 0);
    end
    for (int i = 0; i < D; i++) begin
      expa[i] = '0;
      expb[i] = '0;
    end
    run_pass("arst_banks_zero", 3'd3, 3, 22'd0);

    // Over-long length clamps to DEPTH: 5+12+21+32 = 70.
    load(10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8);
    run_pass("clamp", 3'd7, 4, 22'd70);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vetor_feeder.md
Name: vetor_feeder

Overview:
- Upstream operand sequencer for the multiply-accumulate stage (10-bit k, l inputs; 22-bit accumulator that adds k*l on every clock edge).
- Holds two operand vectors A and B in local register banks, loaded through a write port.
- On start, streams element pairs (A[i], B[i]) onto k/l, one pair per clock, and emits an accumulator-clear pulse first.
- Drives k = l = 0 at all other times, so the free-running accumulator holds its value.

Parameters:
- WIDTH, 10, element width; must match the MAC k/l width.
- DEPTH, 4, maximum vector length. 4 × 1023² = 4,186,116 < 2²², so the 22-bit accumulator never overflows.
- ADDR_W, 2, element address width, equal to clog2(DEPTH).

Ports:
- clock  in  1  rising-edge system clock.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  element write strobe.
- wr_sel  in  1  bank select: 0 = A, 1 = B.
- wr_addr  in  ADDR_W  element index.
- wr_data  in  WIDTH  element value.
- len  in  ADDR_W+1  vector length; sampled on an accepted start; legal range 0..DEPTH.
- start  in  1  single-cycle request to begin a pass.
- busy  out  1  high from the cycle after start is accepted until done is asserted (exclusive).
- acc_clear  out  1  one-cycle pulse; downstream forces its accumulator to 0.
- k  out  WIDTH  operand A element (to the MAC).
- l  out  WIDTH  operand B element (to the MAC).
- pair_valid  out  1  high while k/l carry a real pair.
- last  out  1  high together with the final pair.
- done  out  1  one-cycle pulse after the final pair.
- wr_err  out  1  sticky; set when a write is attempted while busy; cleared by reset or by an accepted start.

Behaviour:
- Reset (async):
  - All outputs are 0; state is IDLE; index is 0.
  - Bank contents are cleared to 0.
  - Reset mid-pass aborts immediately: no done pulse, and k/l return to 0.
- All outputs are registered; no combinational path from inputs to outputs.
- States:
  - IDLE → CLEAR when start=1.
  - CLEAR → STREAM when the latched len > 0.
  - CLEAR → FINISH when the latched len = 0.
  - STREAM → STREAM while index < len-1, incrementing the index.
  - STREAM → FINISH at index = len-1.
  - FINISH → IDLE unconditionally.
- Cycle timing (start sampled at edge T):
  - T+1: acc_clear=1, busy=1, k=l=0.
  - T+2 … T+1+len: k=A[i], l=B[i], pair_valid=1 (i = 0..len-1).
  - T+1+len: last=1 (the final pair cycle).
  - T+2+len: done=1, busy=0, k=l=0.
  - Downstream accumulator holds the final dot product from edge T+3+len onward.
- len > DEPTH is clamped to DEPTH. len = 0 gives acc_clear followed directly by done, with no pairs.
- Outside STREAM: k=l=0 and pair_valid=0.
- start while busy (CLEAR/STREAM/FINISH) is ignored. start in the same cycle as done is ignored; the next start is accepted in IDLE.
- Writes:
  - Accepted only in IDLE.
  - A write while busy is dropped and sets wr_err.
  - A write and a start in the same IDLE cycle: the write lands first, so the pass uses the new value.
- A write to an address ≥ DEPTH (only possible if DEPTH is not a power of 2) is ignored.

Decomposition:
- Shared package vetor_pkg:
  - state enum {IDLE, CLEAR, STREAM, FINISH};
  - WIDTH = 10;
  - ACC_W = 22 (shared with the MAC).
- One natural sub-module, vetor_bank: a DEPTH×WIDTH register file with one sync write port and one async read port, instantiated once for A and once for B.

Test Plan:
- Load A={3,4,5}, B={6,7,8}; len=3; start.
  - Required: acc_clear at T+1; k/l = 3/6, 4/7, 5/8 at T+2..T+4; last at T+4; done at T+5.
  - Chained MAC reads 18, 46, 86.
- All elements 1023, len=4.
  - Required: four pairs of 1023/1023; chained MAC = 4,186,116 with no wrap.
- len=0, start.
  - Required: acc_clear at T+1; done at T+2; pair_valid never high; MAC = 0.
- start pulsed again at T+3 mid-pass, plus a write to A[0].
  - Required: the pass is unchanged; A[0] is unchanged; wr_err=1.
  - A following start clears wr_err.
- Assert reset at T+3 during STREAM.
  - Required: all outputs are 0 in the same cycle (async); no done pulse; banks are 0 after reset.
- len=7 with DEPTH=4.
  - Required: clamped to 4 pairs; done at T+6.
